// File: rtl/float_widen.sv
// Widens an IEEE-style float to a wider format; accept-to-valid is 2 edges, plus one per normalise step for subnormals.
// stb/ack handshake on both sides, one operand in flight; output_z is held until the consumer acks it.
module float_widen #(
    parameter int IN_E_W       = 8,
    parameter int IN_M_W       = 23,
    parameter int OUT_E_W      = 11,
    parameter int OUT_M_W      = 52,
    parameter int FLUSH_DENORM = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IN_E_W+IN_M_W:0]       input_a,
    input  logic                         input_a_stb,
    output logic                         input_a_ack,
    output logic [OUT_E_W+OUT_M_W:0]     output_z,
    output logic                         output_z_stb,
    input  logic                         output_z_ack,
    output logic                         output_z_invalid
);

    localparam int EW   = OUT_E_W + 1;
    localparam int IB_I = (1 << (IN_E_W - 1)) - 1;
    localparam int OB_I = (1 << (OUT_E_W - 1)) - 1;

    localparam logic [OUT_E_W:0]   IB     = EW'(IB_I);
    localparam logic [OUT_E_W:0]   OB     = EW'(OB_I);
    localparam logic [OUT_E_W:0]   SUB_E  = OB + EW'(1) - IB;
    localparam logic [OUT_E_W-1:0] E_ONES = '1;
    localparam logic [OUT_E_W-1:0] E_ZERO = '0;
    localparam logic [OUT_M_W-1:0] M_ZERO = '0;

    typedef enum logic [1:0] {GET_A, CONVERT, NORMALISE, PUT_Z} state_t;

    state_t                     state_q;
    logic [IN_E_W+IN_M_W:0]     a_q;
    logic [OUT_E_W:0]           z_e_q;
    logic [OUT_M_W:0]           z_m_q;
    logic [OUT_E_W+OUT_M_W:0]   res_q;
    logic                       res_inv_q;
    logic                       ack_q;
    logic                       stb_q;
    logic [OUT_E_W+OUT_M_W:0]   z_q;
    logic                       inv_q;

    logic                       a_s;
    logic [IN_E_W-1:0]          a_e;
    logic [IN_M_W-1:0]          a_m;
    logic [OUT_E_W:0]           norm_e_d;
    logic [OUT_M_W-1:0]         m_align_d;
    logic [OUT_M_W-1:0]         nan_m_d;
    logic                       unused_e_msb;

    assign a_s = a_q[IN_E_W+IN_M_W];
    assign a_e = a_q[IN_E_W+IN_M_W-1:IN_M_W];
    assign a_m = a_q[IN_M_W-1:0];

    // Rebias in the extended width so no intermediate wraps.
    assign norm_e_d  = EW'(a_e) - IB + OB;
    assign m_align_d = OUT_M_W'(a_m) << (OUT_M_W - IN_M_W);
    assign nan_m_d   = m_align_d | (OUT_M_W'(1) << (OUT_M_W - 1));

    assign unused_e_msb = norm_e_d[OUT_E_W] ^ z_e_q[OUT_E_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= GET_A;
            a_q       <= '0;
            z_e_q     <= '0;
            z_m_q     <= '0;
            res_q     <= '0;
            res_inv_q <= 1'b0;
            ack_q     <= 1'b0;
            stb_q     <= 1'b0;
            z_q       <= '0;
            inv_q     <= 1'b0;
        end else begin
            case (state_q)
                GET_A: begin
                    if (ack_q && input_a_stb) begin
                        a_q     <= input_a;
                        ack_q   <= 1'b0;
                        state_q <= CONVERT;
                    end else begin
                        ack_q <= 1'b1;
                    end
                end
                CONVERT: begin
                    res_inv_q <= 1'b0;
                    state_q   <= PUT_Z;
                    if (a_e == '1) begin
                        if (a_m == '0) begin
                            res_q <= {a_s, E_ONES, M_ZERO};
                        end else begin
                            res_q     <= {a_s, E_ONES, nan_m_d};
                            res_inv_q <= ~a_m[IN_M_W-1];
                        end
                    end else if (a_e == '0) begin
                        if (a_m == '0 || FLUSH_DENORM != 0) begin
                            res_q <= {a_s, E_ZERO, M_ZERO};
                        end else begin
                            z_e_q   <= SUB_E;
                            z_m_q   <= {1'b0, m_align_d};
                            state_q <= NORMALISE;
                        end
                    end else begin
                        res_q <= {a_s, norm_e_d[OUT_E_W-1:0], m_align_d};
                    end
                end
                NORMALISE: begin
                    if (z_m_q[OUT_M_W]) begin
                        res_q   <= {a_s, z_e_q[OUT_E_W-1:0], z_m_q[OUT_M_W-1:0]};
                        state_q <= PUT_Z;
                    end else begin
                        z_m_q <= z_m_q << 1;
                        z_e_q <= z_e_q - EW'(1);
                    end
                end
                PUT_Z: begin
                    // Result is copied only on entry so it cannot move while stb is up.
                    if (stb_q && output_z_ack) begin
                        stb_q   <= 1'b0;
                        state_q <= GET_A;
                    end else if (!stb_q) begin
                        stb_q <= 1'b1;
                        z_q   <= res_q;
                        inv_q <= res_inv_q;
                    end
                end
                default: state_q <= GET_A;
            endcase
        end
    end

    assign input_a_ack      = ack_q;
    assign output_z_stb     = stb_q;
    assign output_z         = z_q;
    assign output_z_invalid = inv_q;

endmodule

// File: tb/tb_float_widen.sv
// Directed checks of float_widen: default instance plus a FLUSH_DENORM=1 instance.
module tb_float_widen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a_in  [2];
    logic        a_stb [2];
    logic        a_ack [2];
    logic [63:0] z_out [2];
    logic        z_stb [2];
    logic        z_ack [2];
    logic        z_inv [2];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    float_widen u_dut (
        .clk(clk), .rst(rst),
        .input_a(a_in[0]), .input_a_stb(a_stb[0]), .input_a_ack(a_ack[0]),
        .output_z(z_out[0]), .output_z_stb(z_stb[0]), .output_z_ack(z_ack[0]),
        .output_z_invalid(z_inv[0])
    );

    float_widen #(.FLUSH_DENORM(1)) u_dut_flush (
        .clk(clk), .rst(rst),
        .input_a(a_in[1]), .input_a_stb(a_stb[1]), .input_a_ack(a_ack[1]),
        .output_z(z_out[1]), .output_z_stb(z_stb[1]), .output_z_ack(z_ack[1]),
        .output_z_invalid(z_inv[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic accept(input int d, input string name, input logic [31:0] a);
        int n = 0;
        while (!a_ack[d] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_ack_rdy"}, 64'(a_ack[d]), 64'd1);
        a_in[d]  = a;
        a_stb[d] = 1'b1;
        @(posedge clk); #1;
        a_stb[d] = 1'b0;
        chk({name, "_ack_drop"}, 64'(a_ack[d]), 64'd0);
    endtask

    task automatic wait_stb(input int d, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!z_stb[d] && lat < 200);
    endtask

    task automatic take(input int d, input string name);
        z_ack[d] = 1'b1;
        @(posedge clk); #1;
        z_ack[d] = 1'b0;
        chk({name, "_stb_drop"}, 64'(z_stb[d]), 64'd0);
    endtask

    task automatic run(input int d, input string name, input logic [31:0] a,
                       input logic [63:0] ez, input logic ei, input int elat);
        int lat;
        accept(d, name, a);
        wait_stb(d, lat);
        chk({name, "_lat"}, 64'(lat), 64'(elat));
        chk({name, "_z"}, z_out[d], ez);
        chk({name, "_inv"}, 64'(z_inv[d]), 64'(ei));
        take(d, name);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 2; i++) begin
            a_in[i] = '0; a_stb[i] = 1'b0; z_ack[i] = 1'b0;
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 64'(a_ack[0]), 64'd0);
        chk("rst_stb", 64'(z_stb[0]), 64'd0);
        chk("rst_z", z_out[0], 64'd0);
        chk("rst_inv", 64'(z_inv[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("first_ack", 64'(a_ack[0]), 64'd1);
        chk("first_ack_fl", 64'(a_ack[1]), 64'd1);

        run(0, "one",     32'h3F800000, 64'h3FF0000000000000, 1'b0, 2);
        run(0, "npi",     32'hC0490FDB, 64'hC00921FB60000000, 1'b0, 2);
        run(0, "sub_min", 32'h00000001, 64'h36A0000000000000, 1'b0, 26);
        run(0, "sub_top", 32'h00400000, 64'h3800000000000000, 1'b0, 4);
        run(0, "sub_neg", 32'h80400000, 64'hB800000000000000, 1'b0, 4);
        run(0, "ninf",    32'hFF800000, 64'hFFF0000000000000, 1'b0, 2);
        run(0, "nzero",   32'h80000000, 64'h8000000000000000, 1'b0, 2);
        run(0, "snan",    32'h7F800001, 64'h7FF8000020000000, 1'b1, 2);
        run(0, "qnan",    32'h7FC00000, 64'h7FF8000000000000, 1'b0, 2);
        run(1, "flush",   32'h80000001, 64'h8000000000000000, 1'b0, 2);

        // Consumer stalls for 10 cycles.
        accept(0, "bp", 32'h3F800000);
        wait_stb(0, lat);
        chk("bp_lat", 64'(lat), 64'd2);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_z", z_out[0], 64'h3FF0000000000000);
            chk("bp_stb", 64'(z_stb[0]), 64'd1);
            chk("bp_ack", 64'(a_ack[0]), 64'd0);
        end
        take(0, "bp");

        // Reset in the middle of normalising a subnormal.
        accept(0, "mid", 32'h00000001);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_ack", 64'(a_ack[0]), 64'd0);
        chk("mid_rst_stb", 64'(z_stb[0]), 64'd0);
        chk("mid_rst_z", z_out[0], 64'd0);
        chk("mid_rst_inv", 64'(z_inv[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_first_ack", 64'(a_ack[0]), 64'd1);
        chk("mid_no_stb", 64'(z_stb[0]), 64'd0);
        run(0, "after", 32'h3F800000, 64'h3FF0000000000000, 1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
